// File: rtl/fsk_modulator_if.sv
// Symbol handshake between a symbol source and the FSK modulator.
// The transmitter (master) drives symbol/valid, and the modulator (slave) answers with ready.
interface fsk_modulator_if #(
  parameter int OUTPUT_BITS = 1
);
  logic [OUTPUT_BITS-1:0] symbol_i;
  logic                   symbol_valid_i;
  logic                   symbol_ready_o;

  modport master (output symbol_i, output symbol_valid_i, input symbol_ready_o);
  modport slave  (input symbol_i, input symbol_valid_i, output symbol_ready_o);
endinterface

// File: rtl/fsk_modulator.sv
// Phase-continuous FSK modulator: each accepted symbol selects a tuning word
// that drives a phase accumulator for SYMBOL_CYCLES clocks; freq_o is the accumulator MSB.
module fsk_modulator #(
  parameter int OUTPUT_BITS     = 1,
  parameter int NUM_FREQUENCIES = 2**OUTPUT_BITS,
  parameter int ACC_BITS        = 32,
  parameter int SYMBOL_CYCLES   = 200
) (
  input  logic                clk_200M,
  input  logic                reset_200M,
  input  logic [ACC_BITS-1:0] tuning_base_i,
  input  logic [ACC_BITS-1:0] tuning_step_i,
  input  logic                carrier_en_i,
  fsk_modulator_if.slave      sym_if,
  output logic                busy_o,
  output logic [ACC_BITS-1:0] tuning_word_o,
  output logic                freq_o
);
  localparam int CNT_W = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_CYCLES - 1);
  localparam logic [ACC_BITS-1:0] SYM_MAX = ACC_BITS'(NUM_FREQUENCIES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [ACC_BITS-1:0] tw_q, tw_d;

  logic                ready;
  logic                xfer;
  logic [ACC_BITS-1:0] sym_word;
  logic [ACC_BITS-1:0] tw_load;

  always_ff @(posedge clk_200M or posedge reset_200M) begin
    if (reset_200M) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      tw_q    <= tw_d;
    end
  end

  always_comb begin
    ready = (state_q == IDLE) || (cnt_q == CNT_LAST);
    xfer  = sym_if.symbol_valid_i && ready;

    // Symbols beyond the configured tone set saturate to the highest tone.
    sym_word = ACC_BITS'(sym_if.symbol_i);
    if (sym_word > SYM_MAX) sym_word = SYM_MAX;
    tw_load = tuning_base_i + sym_word * tuning_step_i;

    // Phase keeps running across symbols and idle; only an idle, disabled carrier clears it.
    acc_d = ((state_q == SEND) || carrier_en_i) ? acc_q + tw_q : '0;

    state_d = state_q;
    cnt_d   = cnt_q;
    tw_d    = tw_q;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SEND;
          cnt_d   = '0;
          tw_d    = tw_load;
        end else begin
          tw_d    = tuning_base_i;
        end
      end
      SEND: begin
        if (xfer) begin
          cnt_d   = '0;
          tw_d    = tw_load;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          tw_d    = tuning_base_i;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sym_if.symbol_ready_o = ready;
  assign busy_o        = (state_q == SEND);
  assign tuning_word_o = tw_q;
  assign freq_o        = acc_q[ACC_BITS-1];
endmodule
